// File: rtl/fetch_pkg.sv
// Shared encodings for the fetch redirect controller and the PC vector mux.
`default_nettype none

package fetch_pkg;

  typedef enum logic [1:0] {
    STRT  = 2'd0,
    NORM  = 2'd1,
    REDIR = 2'd2
  } state_e;

  localparam int unsigned RSTSRC = 0;

  // Vector select code for exception line k.
  function automatic int unsigned src_code(input int unsigned k);
    return k + 1;
  endfunction

  // Vector select code for the interrupt (one past the last exception).
  function automatic int unsigned int_src(input int unsigned num_expt);
    return num_expt + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_prio_enc.sv
// Priority encoder: lowest set request index wins; vld flags any request.
`default_nettype none

module fetch_prio_enc #(
  parameter int W     = 3,
  parameter int IDX_W = 2
) (
  input  logic [W-1:0]     req,
  output logic [IDX_W-1:0] idx,
  output logic             vld
);

  always_comb begin
    idx = '0;
    vld = |req;
    for (int i = W - 1; i >= 0; i--) begin
      if (req[i]) idx = IDX_W'(i);
    end
  end

endmodule

`default_nettype wire

// File: rtl/fetch_redirect_ctrl.sv
// Fetch redirect controller: prioritised reset/exception/interrupt redirects
// with multi-cycle hold, preemption and a pending mask for deferred events.
`default_nettype none

module fetch_redirect_ctrl
  import fetch_pkg::*;
#(
  parameter  int NUM_EXPT      = 2,
  parameter  int EXTEND_CYCLES = 1,
  localparam int SRC_W         = $clog2(NUM_EXPT + 2),
  localparam int CNT_W         = $clog2(EXTEND_CYCLES + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid,
  input  logic                flush,
  input  logic                int_req,
  input  logic [NUM_EXPT-1:0] expt,
  output logic                extend,
  output logic                fetch,
  output logic [SRC_W-1:0]    fetchSrc,
  output logic                busy,
  output logic [NUM_EXPT:0]   pending
);

  localparam int NP = NUM_EXPT + 1;
  localparam logic [SRC_W-1:0] INT_CODE = SRC_W'(int_src(NUM_EXPT));
  localparam logic [SRC_W-1:0] RST_CODE = SRC_W'(RSTSRC);

  // Source code <-> priority rank (0 = highest); the mapping is its own inverse.
  function automatic logic [SRC_W-1:0] swap_rank(input logic [SRC_W-1:0] v);
    if (v == INT_CODE)      return RST_CODE;
    else if (v == RST_CODE) return INT_CODE;
    else                    return v;
  endfunction

  // Pending/request bit for a source: bit src-1 (reset has none).
  function automatic logic [NP-1:0] src_mask(input logic [SRC_W-1:0] src);
    if (src == RST_CODE) return '0;
    else                 return NP'(1) << (src - SRC_W'(1));
  endfunction

  state_e           state_q, state_d;
  logic [SRC_W-1:0] cur_src_q, cur_src_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [NP-1:0]    pend_q, pend_d;

  logic [NP-1:0]    req_spec, add_mask, drop_mask, pend_base;
  logic [SRC_W-1:0] req_idx, pend_idx, new_src, pend_src;
  logic             req_vld, pend_vld, preempt, take, hold_last;

  assign req_spec = {int_req, expt};

  fetch_prio_enc #(.W(NP), .IDX_W(SRC_W)) u_req_enc (
    .req ({expt, int_req}),
    .idx (req_idx),
    .vld (req_vld)
  );

  assign new_src = swap_rank(req_idx);

  always_comb begin
    preempt   = (state_q == REDIR) && req_vld &&
                (req_idx < swap_rank(cur_src_q));
    take      = req_vld && ((state_q != REDIR) || preempt);
    drop_mask = '0;
    if (take)             drop_mask = drop_mask | src_mask(new_src);
    if (state_q == REDIR) drop_mask = drop_mask | src_mask(cur_src_q);
    add_mask  = req_spec & ~drop_mask;
  end

  // New captures are applied after the flush clear so same-cycle events survive.
  assign pend_base = (flush ? '0 : pend_q) | add_mask;

  fetch_prio_enc #(.W(NP), .IDX_W(SRC_W)) u_pend_enc (
    .req ({pend_base[NUM_EXPT-1:0], pend_base[NUM_EXPT]}),
    .idx (pend_idx),
    .vld (pend_vld)
  );

  assign pend_src  = swap_rank(pend_idx);
  assign hold_last = (hold_cnt_q == CNT_W'(EXTEND_CYCLES - 1));

  always_comb begin
    state_d    = state_q;
    cur_src_d  = cur_src_q;
    hold_cnt_d = hold_cnt_q;
    pend_d     = pend_base;
    case (state_q)
      STRT: begin
        state_d    = REDIR;
        hold_cnt_d = '0;
        cur_src_d  = req_vld ? new_src : RST_CODE;
      end
      NORM: begin
        if (req_vld) begin
          state_d    = REDIR;
          hold_cnt_d = '0;
          cur_src_d  = new_src;
        end
      end
      REDIR: begin
        if (preempt) begin
          cur_src_d  = new_src;
          hold_cnt_d = '0;
        end else if (valid) begin
          if (hold_last) begin
            hold_cnt_d = '0;
            if (pend_vld) begin
              cur_src_d = pend_src;
              pend_d    = pend_base & ~src_mask(pend_src);
            end else begin
              state_d = NORM;
            end
          end else begin
            hold_cnt_d = hold_cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = STRT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= STRT;
      cur_src_q  <= '0;
      hold_cnt_q <= '0;
      pend_q     <= '0;
    end else begin
      state_q    <= state_d;
      cur_src_q  <= cur_src_d;
      hold_cnt_q <= hold_cnt_d;
      pend_q     <= pend_d;
    end
  end

  assign busy     = (state_q == REDIR);
  assign extend   = busy && valid;
  assign fetch    = busy && valid && (hold_cnt_q == '0);
  assign fetchSrc = (busy && valid) ? cur_src_q : '0;
  assign pending  = pend_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_redirect_ctrl.sv
// Directed bench: four controller configurations driven from one stimulus sequence.
`default_nettype none

module tb_fetch_redirect_ctrl;

  logic       clk = 1'b0;
  logic       rst, rst_d, valid, flush, irq;
  logic [1:0] expt;
  logic [4:0] expt5;

  int checks = 0;
  int errors = 0;

  logic       a_ext, a_fet, a_busy, b_ext, b_fet, b_busy, c_ext, c_fet, c_busy;
  logic       d_ext, d_fet, d_busy;
  logic [1:0] a_src, b_src, c_src;
  logic [2:0] a_pend, b_pend, c_pend, d_src;
  logic [5:0] d_pend;

  always #5 clk = ~clk;

  fetch_redirect_ctrl #(.NUM_EXPT(2), .EXTEND_CYCLES(1)) u_a (
    .clk(clk), .rst(rst), .valid(valid), .flush(flush), .int_req(irq), .expt(expt),
    .extend(a_ext), .fetch(a_fet), .fetchSrc(a_src), .busy(a_busy), .pending(a_pend));

  fetch_redirect_ctrl #(.NUM_EXPT(2), .EXTEND_CYCLES(3)) u_b (
    .clk(clk), .rst(rst), .valid(valid), .flush(flush), .int_req(irq), .expt(expt),
    .extend(b_ext), .fetch(b_fet), .fetchSrc(b_src), .busy(b_busy), .pending(b_pend));

  fetch_redirect_ctrl #(.NUM_EXPT(2), .EXTEND_CYCLES(4)) u_c (
    .clk(clk), .rst(rst), .valid(valid), .flush(flush), .int_req(irq), .expt(expt),
    .extend(c_ext), .fetch(c_fet), .fetchSrc(c_src), .busy(c_busy), .pending(c_pend));

  fetch_redirect_ctrl #(.NUM_EXPT(5), .EXTEND_CYCLES(1)) u_d (
    .clk(clk), .rst(rst_d), .valid(valid), .flush(flush), .int_req(irq), .expt(expt5),
    .extend(d_ext), .fetch(d_fet), .fetchSrc(d_src), .busy(d_busy), .pending(d_pend));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      valid = 1'b1; flush = 1'b0; irq = 1'b0; expt = '0; expt5 = '0;
      tick();
    end
  endtask

  initial begin
    rst = 1'b0; rst_d = 1'b0; valid = 1'b1; flush = 1'b0;
    irq = 1'b0; expt = '0; expt5 = '0;
    tick(); tick();
    #1;
    chk("rst_busy", a_busy, 0);
    chk("rst_fetch", a_fet, 0);
    chk("rst_pend", a_pend, 0);

    // Reset release, no events
    rst = 1'b1; #1;
    chk("c1_extend", a_ext, 0);
    chk("c1_fetch", a_fet, 0);
    tick(); #1;
    chk("c2_fetch", a_fet, 1);
    chk("c2_extend", a_ext, 1);
    chk("c2_src", a_src, 0);
    tick(); #1;
    chk("c3_busy", a_busy, 0);
    chk("c3_fetch", a_fet, 0);
    idle(8);

    // EXTEND_CYCLES=3 with valid pattern 1,0,1,1
    expt = 2'b10; #1;
    tick(); expt = '0; valid = 1'b1; #1;
    chk("b_v1_fetch", b_fet, 1);
    chk("b_v1_src", b_src, 2);
    chk("b_v1_ext", b_ext, 1);
    tick(); valid = 1'b0; #1;
    chk("b_v0_ext", b_ext, 0);
    chk("b_v0_fetch", b_fet, 0);
    chk("b_v0_src", b_src, 0);
    chk("b_v0_busy", b_busy, 1);
    tick(); valid = 1'b1; #1;
    chk("b_v2_ext", b_ext, 1);
    chk("b_v2_fetch", b_fet, 0);
    chk("b_v2_src", b_src, 2);
    tick(); #1;
    chk("b_v3_ext", b_ext, 1);
    chk("b_v3_fetch", b_fet, 0);
    tick(); #1;
    chk("b_done_busy", b_busy, 0);
    idle(8);

    // int and expt[0] together: int first, expt[0] pended
    irq = 1'b1; expt = 2'b01; #1;
    tick(); irq = 1'b0; expt = '0; #1;
    chk("a_int_fetch", a_fet, 1);
    chk("a_int_src", a_src, 3);
    chk("a_int_pend", a_pend, 3'b001);
    tick(); #1;
    chk("a_e0_fetch", a_fet, 1);
    chk("a_e0_src", a_src, 1);
    chk("a_e0_pend", a_pend, 0);
    tick(); #1;
    chk("a_norm_busy", a_busy, 0);
    idle(12);

    // EXTEND_CYCLES=4: int preempts expt[1] redirect at hold_cnt=1
    expt = 2'b10; #1;
    tick(); expt = '0; #1;
    chk("c_e1_fetch", c_fet, 1);
    chk("c_e1_src", c_src, 2);
    tick(); irq = 1'b1; #1;
    chk("c_h1_fetch", c_fet, 0);
    chk("c_h1_src", c_src, 2);
    tick(); irq = 1'b0; #1;
    chk("c_pre_fetch", c_fet, 1);
    chk("c_pre_src", c_src, 3);
    tick(); tick(); tick(); #1;
    chk("c_pre_h3_src", c_src, 3);
    chk("c_pre_h3_fetch", c_fet, 0);
    tick(); #1;
    chk("c_noresume_busy", c_busy, 0);
    chk("c_noresume_pend", c_pend, 0);
    idle(10);

    // Flush discards an event pended during an int redirect
    irq = 1'b1; #1;
    tick(); irq = 1'b0; expt = 2'b10; #1;
    chk("c_fl_busy", c_busy, 1);
    chk("c_fl_src", c_src, 3);
    tick(); expt = '0; flush = 1'b1; #1;
    chk("c_fl_pend_set", c_pend, 3'b010);
    tick(); flush = 1'b0; #1;
    chk("c_fl_pend_clr", c_pend, 0);
    tick(); #1;
    chk("c_fl_h3_busy", c_busy, 1);
    tick(); #1;
    chk("c_fl_norm_busy", c_busy, 0);
    chk("c_fl_norm_fetch", c_fet, 0);
    idle(10);

    // NUM_EXPT=5: expt=10100b, then reset mid second redirect
    rst_d = 1'b1; #1;
    tick(); #1;
    chk("d_rv_src", d_src, 0);
    chk("d_rv_fetch", d_fet, 1);
    tick(); expt5 = 5'b10100; #1;
    chk("d_norm_busy", d_busy, 0);
    tick(); expt5 = '0; #1;
    chk("d_r1_fetch", d_fet, 1);
    chk("d_r1_src", d_src, 3);
    chk("d_r1_pend", d_pend, 6'b010000);
    tick(); rst_d = 1'b0; #1;
    chk("d_r2_fetch", d_fet, 1);
    chk("d_r2_src", d_src, 5);
    chk("d_r2_pend", d_pend, 0);
    tick(); #1;
    chk("d_rst_busy", d_busy, 0);
    chk("d_rst_src", d_src, 0);
    chk("d_rst_pend", d_pend, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
